// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a time to
// instruction memory, and presents each fetched instruction under a valid/ready handshake.
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0]   addr_q;
  logic              load_instr;
  logic              drop_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which always blocks evaluate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    load_instr   = 1'b0;
    drop_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (redirect) fetch_pc_nxt = redirect_pc;
      end
      FETCH: begin
        if (redirect) begin
          // Without an ack the request cannot be withdrawn; park the target and drain.
          fetch_pc_nxt = redirect_pc;
          state_nxt    = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          load_instr   = 1'b1;
          fetch_pc_nxt = fetch_pc + PC_W'(1);
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          drop_valid   = 1'b1;
          fetch_pc_nxt = redirect_pc;
          state_nxt    = FETCH;
        end else if (instr_ready) begin
          drop_valid = 1'b1;
          state_nxt  = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) fetch_pc_nxt = redirect_pc;
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == FETCH) || (state == DRAIN);
    imem_addr = addr_q;
  end

  // addr_q tracks fetch_pc except while draining, where it keeps the address in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      addr_q      <= RESET_PC;
      instr       <= '0;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      if (state_nxt != DRAIN) addr_q <= fetch_pc_nxt;
      if (load_instr) begin
        instr       <= imem_rdata;
        instr_pc    <= addr_q;
        instr_valid <= 1'b1;
      end else if (drop_valid) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
